i2c_slave_target: RTL and testbench

- I2C target (responder): the other end of the I2C master inside the APB peripheral.
- Samples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit device address.
- On writes it receives bytes and ACKs them; on reads it transmits bytes supplied by local logic.
- Used as an on-chip bus model and as a real target peripheral; SDA is open-drain (drive-low only).

---
 rtl/i2c_slave_target_pkg.sv | 33 +++
 rtl/i2c_slave_target_if.sv | 20 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_slave_target.sv | 179 +++++++++++++++++
 tb/tb_i2c_slave_target.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_target_pkg.sv
// Shared types and constants for the I2C target; I2C_SLAVE_GENERAL_CALL_EN
// enables write-only acceptance of the general-call address 7'h00.
package i2c_slave_target_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [I2C_ADDR_W-1:0] GEN_CALL_ADDR = 7'h00;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam bit GEN_CALL_EN = 1'b1;
`else
  localparam bit GEN_CALL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX        = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX        = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  // hdr is the full address byte: {addr[6:0], rw}
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] hdr,
                                      input logic [I2C_ADDR_W-1:0] dev);
    return (hdr[I2C_BYTE_W-1:1] == dev) ||
           (GEN_CALL_EN && (hdr[I2C_BYTE_W-1:1] == GEN_CALL_ADDR) && !hdr[0]);
  endfunction

endpackage

// File: rtl/i2c_slave_target_if.sv
// Pad-side and local-logic signals of the I2C target, bundled with
// slave (target) and master (bus model / local logic) views.
interface i2c_slave_target_if;
  import i2c_slave_target_pkg::*;

  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_req;
  logic                  busy;
  logic                  rw;

  modport slave  (input  scl_i, sda_i, tx_data,
                  output sda_oe, rx_data, rx_valid, tx_req, busy, rw);
  modport master (output scl_i, sda_i, tx_data,
                  input  sda_oe, rx_data, rx_valid, tx_req, busy, rw);
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an idle-high I2C pad plus a history flop
// that yields single-cycle rise/fall strobes.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive and
// transmit. I2C_SLAVE_GENERAL_CALL_EN adds general-call write acceptance.
module i2c_slave_target
  import i2c_slave_target_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  i2c_slave_target_if.slave  bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .din_i(bus.scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .din_i(bus.sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  wire bus_start = sda_fall & scl_lvl;
  wire bus_stop  = sda_rise & scl_lvl;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  oe_q, oe_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;
  logic                  rw_q, rw_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (bus_start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      full_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (bus_stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        // full_q tells the post-8th-bit SCL fall apart from the fall after START
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              full_d = 1'b1;
              if (state_q == ST_ADDR) begin
                rw_d = sda_lvl;
              end else begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ST_RX) begin
              state_d = ST_RX_ACK;
              oe_d    = 1'b1;
            end else if (addr_match(shift_q, DEV_ADDR)) begin
              state_d  = ST_ADDR_ACK;
              oe_d     = 1'b1;
              busy_d   = 1'b1;
              tx_req_d = rw_q;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = ST_TX;
              shift_d = bus.tx_data;
              oe_d    = ~bus.tx_data[I2C_BYTE_W-1];
            end else begin
              state_d = ST_RX;
              oe_d    = 1'b0;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d = ST_RX;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              state_d = ST_TX_ACK;
              oe_d    = 1'b0;
            end else begin
              shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
              oe_d    = ~shift_q[I2C_BYTE_W-2];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              tx_req_d = 1'b1;
            end
          end else if (scl_fall) begin
            state_d = ST_TX;
            shift_d = bus.tx_data;
            oe_d    = ~bus.tx_data[I2C_BYTE_W-1];
            cnt_d   = '0;
          end
        end
        ST_WAIT_STOP: oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.sda_oe   = oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.busy     = busy_q;
  assign bus.rw       = rw_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bit-banged I2C master driving the target, with scoreboard queues for
// received bytes (rx_valid monitor) and transmit data (tx_req responder).
module tb_i2c_slave_target;
  import i2c_slave_target_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic [7:0] tx_data_r = 8'h00;

  i2c_slave_target_if bus();

  assign bus.scl_i   = scl_m;
  assign bus.sda_i   = sda_m & ~bus.sda_oe;
  assign bus.tx_data = tx_data_r;

  i2c_slave_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_req_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got %h expected no pulse", bus.rx_data);
      end else begin
        chk("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_rx.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.tx_req) begin
      tx_req_cnt++;
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_req_unexpected got pulse expected none");
      end else begin
        tx_data_r = tx_q.pop_front();
      end
    end
    if (bus.sda_oe) oe_cnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    sda_m = b;  clks(10);
    scl_m = 1'b1; clks(10);
    s = bus.sda_i; clks(10);
    scl_m = 1'b0; clks(10);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; clks(10);
    scl_m = 1'b1; clks(10);
    sda_m = 1'b0; clks(10);
    scl_m = 1'b0; clks(10);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; clks(10);
    scl_m = 1'b1; clks(10);
    sda_m = 1'b1; clks(10);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(mack, s);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         base;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    clks(5); rst = 1'b0; clks(5);

    chk("rst_sda_oe",   bus.sda_oe,   0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_req",   bus.tx_req,   0);
    chk("rst_rw",       bus.rw,       0);
    chk("rst_rx_data",  bus.rx_data,  0);

    // write two bytes
    i2c_start;
    wr_byte(8'hA0, ack); chk("wr_addr_ack", ack, 0);
    chk("wr_busy", bus.busy, 1);
    chk("wr_rw", bus.rw, 0);
    exp_rx.push_back(8'h3C); wr_byte(8'h3C, ack); chk("wr_b0_ack", ack, 0);
    exp_rx.push_back(8'hC3); wr_byte(8'hC3, ack); chk("wr_b1_ack", ack, 0);
    i2c_stop; clks(5);
    chk("wr_busy_stop", bus.busy, 0);

    // read two bytes, NACK the last
    tx_q.push_back(8'h5A); tx_q.push_back(8'hF0);
    base = tx_req_cnt;
    i2c_start;
    wr_byte(8'hA1, ack); chk("rd_addr_ack", ack, 0);
    chk("rd_rw", bus.rw, 1);
    rd_byte(1'b0, d); chk("rd_b0", d, 8'h5A);
    rd_byte(1'b1, d); chk("rd_b1", d, 8'hF0);
    clks(2);
    chk("rd_tx_req_cnt", tx_req_cnt - base, 2);
    chk("rd_nack_oe", bus.sda_oe, 0);
    chk("rd_nack_busy", bus.busy, 0);
    i2c_stop; clks(5);

    // wrong address
    base = oe_cnt;
    i2c_start;
    wr_byte(8'h42, ack); chk("bad_addr_nack", ack, 1);
    wr_byte(8'h06, ack); chk("bad_data_nack", ack, 1);
    chk("bad_oe_never", oe_cnt - base, 0);
    i2c_stop; clks(5);

    // repeated START: write then read
    i2c_start;
    wr_byte(8'hA0, ack); chk("rs_wr_ack", ack, 0);
    exp_rx.push_back(8'h01); wr_byte(8'h01, ack); chk("rs_b0_ack", ack, 0);
    chk("rs_rw_before", bus.rw, 0);
    tx_q.push_back(8'h96);
    base = tx_req_cnt;
    i2c_start;
    wr_byte(8'hA1, ack); chk("rs_rd_ack", ack, 0);
    chk("rs_rw_after", bus.rw, 1);
    rd_byte(1'b1, d); chk("rs_rd_b0", d, 8'h96);
    chk("rs_rx_data", bus.rx_data, 8'h01);
    chk("rs_tx_req_cnt", tx_req_cnt - base, 1);
    i2c_stop; clks(5);

    // general call
    i2c_start;
    wr_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    chk("gc_addr_ack", ack, 0);
    exp_rx.push_back(8'h06);
    wr_byte(8'h06, ack); chk("gc_data_ack", ack, 0);
`else
    chk("gc_addr_nack", ack, 1);
    wr_byte(8'h06, ack); chk("gc_data_nack", ack, 1);
`endif
    i2c_stop; clks(5);

    // reset in the middle of a received byte
    i2c_start;
    wr_byte(8'hA0, ack); chk("mr_addr_ack", ack, 0);
    bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s); bit_x(1'b1, s);
    chk("mr_busy_pre", bus.busy, 1);
    rst = 1'b1; clks(3);
    chk("mr_sda_oe", bus.sda_oe, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_rx_data", bus.rx_data, 0);
    chk("mr_rw", bus.rw, 0);
    rst = 1'b0; clks(5);
    i2c_start;
    wr_byte(8'hA0, ack); chk("mr_re_addr_ack", ack, 0);
    exp_rx.push_back(8'h77); wr_byte(8'h77, ack); chk("mr_re_b0_ack", ack, 0);
    i2c_stop; clks(5);
    chk("mr_busy_stop", bus.busy, 0);

    clks(10);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
